piso_buffer: RTL and testbench
==============================

# piso_buffer

Parallel-in, serial-out block buffer for the Keccak squeeze path. It captures one rate-sized block in a single load handshake and emits it as WIDTH-bit words on a valid/ready stream. Words leave in the order that makes a `sipo_buffer` of the same WIDTH/DEPTH reconstruct the original vector. It sits between the permutation state register and the digest output port, and can truncate the block to a programmable word count (e.g. 4 × 64 bits for SHA3-256).

## Interface

**Parameters**
- `WIDTH`, default 64: word width in bits.
- `DEPTH`, default 17: words per block (17 × 64 = 1088-bit rate).
- `CNT_W`, default `$clog2(DEPTH+1)`: width of word-count fields (derived; not overridden).

**Ports**
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort; discards the block in flight.
- `load_valid`  in  1  block available on `data_in`.
- `load_ready`  out  1  block can be accepted this cycle.
- `data_in`  in  DEPTH*WIDTH  parallel block.
- `num_words`  in  CNT_W  words to emit, sampled at load.
- `out_valid`  out  1  `data_out` holds a valid word.
- `out_ready`  in  1  sink accepts the word.
- `data_out`  out  WIDTH  current word.
- `out_last`  out  1  current word is the final word of the block.

## Operation

- **States:** IDLE, SHIFT.
- **IDLE:**
  - `load_ready` = 1 (unless `clear` is high).
  - On load handshake: capture `data_in` into slots `0..DEPTH-1`, where slot k = `data_in[(DEPTH-k)*WIDTH-1 -: WIDTH]`. Slot 0 therefore holds the MSB word.
  - Set remaining = effective count and go to SHIFT.
- **Effective count:**
  - `num_words` = 0 or `num_words` > DEPTH → DEPTH.
  - Otherwise `num_words`.
- **SHIFT:**
  - `out_valid` = 1 and `data_out` = slot 0.
  - `out_last` = (remaining == 1).
  - On an out handshake (`out_valid && out_ready`): slots shift toward 0, slot DEPTH-1 fills with 0, and remaining decrements.
  - If the handshake was on the last word, go to IDLE.
  - `data_out` is held stable while `out_valid && !out_ready`.
- **`clear`:**
  - From any state, next state is IDLE, remaining = 0, and slots are zeroed.
  - `load_ready` = 0 while `clear` is high.
  - An out handshake coinciding with `clear` is discarded internally.
- **Outputs derived from state only:** `out_valid`, `out_last`, `data_out`. No combinational path from `out_ready` to `out_valid`/`data_out`.
- **`load_ready`:** combinational from state, `clear`, and (if configured) `out_ready`.

## Timing

- **Reset values** while `rst_n` is low and after release:
  - State IDLE, remaining 0, all slots 0.
  - `out_valid` = 0, `out_last` = 0, `data_out` = 0.
  - `load_ready` = 1 (with `clear` low).
- **Latency:**
  - Load handshake at edge N → `out_valid` = 1 with the first word in the cycle after N.
  - With continuous `out_ready`, an n-word block occupies n cycles in SHIFT.
- **End of block:** the last-word handshake at edge M → `out_valid` = 0 in the cycle after M, unless a back-to-back load occurs (see Configuration).
- **Reset mid-operation:** the block is lost immediately; nothing further is emitted.
- **`num_words` = 1:** `out_last` = 1 on the very first word.

## Configuration

- **Macro:** `PISO_BACK_TO_BACK_EN`.
- **Defined:**
  - `load_ready` is also 1 in SHIFT when `out_last && out_ready && !clear`.
  - A load in that cycle replaces the slots and remaining, and the block stays in SHIFT.
  - `out_valid` stays 1 and the next cycle shows the new block's first word, giving zero bubble between blocks.
- **Not defined:**
  - `load_ready` is 1 only in IDLE.
  - Consecutive blocks are separated by at least one cycle with `out_valid` = 0.

## Test plan

All scenarios use WIDTH=8, DEPTH=4.

1. **Reset:** assert `rst_n` = 0 asynchronously mid-cycle → `out_valid` = 0, `data_out` = 0x00, `load_ready` = 1 immediately. After release, `out_valid` is still 0.
2. **Full block:** load `0xA1B2C3D4` with `num_words` = 0 and `out_ready` held at 1 → emits A1, B2, C3, D4 on consecutive cycles, `out_last` only on D4, then `out_valid` = 0. Loopback into `sipo_buffer` (4×8) reproduces `0xA1B2C3D4`.
3. **Truncation and backpressure:**
   - `num_words` = 2 → A1, B2 with `out_last` on B2.
   - `num_words` = 7 → all 4 words.
   - `out_ready` toggling 1,0,0,1 → `data_out` held at B2 during the stalls; no word is lost or duplicated.
4. **Back-to-back:** load `0x11223344`, then `0x55667788` offered during word 44 with `out_ready` = 1.
   - With `PISO_BACK_TO_BACK_EN`: 11,22,33,44,55,66,77,88 with no gap.
   - Without it: exactly one idle cycle between 44 and 55.
5. **Clear:** pulse `clear` after word B2 with `load_valid` = 1 in the same cycle → load not accepted, `out_valid` = 0 next cycle, C3/D4 never appear. A following load of `0x0F0E0D0C` emits 0F first.
6. **Reset mid-block:** drop `rst_n` after word A1 → no further words. A new load after release emits from its own first word.

Source files
------------

// File: rtl/piso_buffer.sv
// ----------------------------------------------------------------------------
// piso_buffer
//
// Parallel-in, serial-out block buffer for the Keccak squeeze path. One load
// handshake captures a full rate-sized block. The block then leaves as WIDTH-bit
// words on a valid/ready stream, most-significant word first. This order lets a
// sipo_buffer with the same WIDTH/DEPTH rebuild the original vector. The block
// can be cut short to a programmable word count, for example 4 x 64 bits for
// SHA3-256.
//
// Optional feature (compile-time macro):
//   PISO_BACK_TO_BACK_EN  - while the last word of a block is being accepted,
//                           accept the next block in the same cycle so there
//                           is no bubble between blocks. When the macro is not
//                           defined, a load is accepted only in the idle state.
//
// Parameters:
//   WIDTH  word width in bits
//   DEPTH  words per block
//   CNT_W  width of the word-count fields (derived, do not override)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   clear       synchronous abort, discards the block in flight
//   load_valid  block available on data_in
//   load_ready  block can be accepted this cycle
//   data_in     parallel block, DEPTH*WIDTH bits
//   num_words   words to emit (0 or > DEPTH means DEPTH), sampled at load
//   out_valid   data_out holds a valid word
//   out_ready   sink accepts the word
//   data_out    current word
//   out_last    current word is the final word of the block
// ----------------------------------------------------------------------------

module piso_buffer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 17,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [DEPTH*WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0]       num_words,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic                   out_last
);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] slots_q [DEPTH];
    logic [CNT_W-1:0] remaining_q;

    logic [WIDTH-1:0] load_slots  [DEPTH];
    logic [WIDTH-1:0] shift_slots [DEPTH];
    logic [CNT_W-1:0] eff_count;
    logic             load_fire;
    logic             out_fire;

    // Slot 0 takes the most-significant word, so it is the first word out.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            load_slots[k] = data_in[(DEPTH - k) * WIDTH - 1 -: WIDTH];
        end
    end

    // After each accepted word, the slots move one place toward slot 0.
    always_comb begin
        for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
            shift_slots[k] = slots_q[k + 1];
        end
        shift_slots[DEPTH - 1] = '0;
    end

    // A zero or out-of-range count means a full block.
    always_comb begin
        if (num_words == '0 || num_words > CNT_W'(DEPTH)) begin
            eff_count = CNT_W'(DEPTH);
        end else begin
            eff_count = num_words;
        end
    end

    // The stream outputs depend only on registered state. out_ready never
    // reaches out_valid or data_out.
    always_comb begin
        out_valid = (state_q == StShift);
        out_last  = out_valid && (remaining_q == CNT_W'(1));
        data_out  = out_valid ? slots_q[0] : '0;
    end

`ifdef PISO_BACK_TO_BACK_EN
    // The next block may enter in the same cycle as the current last word.
    always_comb begin
        load_ready = !clear && ((state_q == StIdle) || (out_last && out_ready));
    end
`else
    always_comb begin
        load_ready = !clear && (state_q == StIdle);
    end
`endif

    // A word accepted while clear is high is dropped along with the block.
    assign out_fire  = out_valid && out_ready && !clear;
    assign load_fire = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            slots_q     <= '{default: '0};
        end else if (clear) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            slots_q     <= '{default: '0};
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_fire) begin
                        slots_q     <= load_slots;
                        remaining_q <= eff_count;
                        state_q     <= StShift;
                    end
                end
                StShift: begin
                    if (load_fire) begin
                        // A back-to-back load replaces the block that is just ending.
                        slots_q     <= load_slots;
                        remaining_q <= eff_count;
                        state_q     <= StShift;
                    end else if (out_fire) begin
                        slots_q     <= shift_slots;
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (out_last) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_buffer.sv
// ----------------------------------------------------------------------------
// tb_piso_buffer
//
// Directed bench for piso_buffer (WIDTH=8, DEPTH=4). A scoreboard queue holds
// the expected words with their last flags. Entries are pushed when the bench
// predicts that a load is accepted. They are popped when a word is accepted by
// the sink. The queue also predicts out_valid and load_ready in every cycle.
// Define PISO_BACK_TO_BACK_EN to match a DUT built with that macro.
// ----------------------------------------------------------------------------

module tb_piso_buffer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;
`ifdef PISO_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clear;
    logic                   load_valid;
    logic                   load_ready;
    logic [DEPTH*WIDTH-1:0] data_in;
    logic [CNT_W-1:0]       num_words;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       data_out;
    logic                   out_last;

    logic [8:0]  sb[$];    // {last, word}
    int unsigned total;
    int unsigned passed;
    logic        loaded;
    logic [31:0] rebuilt;  // sink-side reconstruction, as a sipo_buffer would

    piso_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .num_words  (num_words),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_block(input logic [31:0] blk, input logic [CNT_W-1:0] n);
        int unsigned eff;
        eff = (n == 0 || n > DEPTH) ? DEPTH : int'(n);
        for (int unsigned i = 0; i < eff; i++) begin
            sb.push_back({(i == eff - 1), blk[31 - 8 * i -: 8]});
        end
    endtask

    // One clock cycle. Checks are made on the falling edge, then the model is
    // updated. The task returns 1 ns after the next rising edge.
    task automatic tick();
        logic       exp_valid;
        logic       exp_lr;
        logic [8:0] head;
        @(negedge clk);
        exp_valid = (sb.size() != 0);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            head = sb[0];
            check("data_out", 32'(data_out), 32'(head[7:0]));
            check("out_last", 32'(out_last), 32'(head[8]));
        end
        exp_lr = !clear && (!exp_valid || (B2B && sb.size() == 1 && out_ready));
        check("load_ready", 32'(load_ready), 32'(exp_lr));
        loaded = 1'b0;
        if (clear) begin
            sb.delete();
        end else begin
            if (exp_valid && out_ready) begin
                head    = sb.pop_front();
                rebuilt = {rebuilt[23:0], head[7:0]};
            end
            if (load_valid && exp_lr) begin
                push_block(data_in, num_words);
                loaded = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Holds load_valid until the model predicts acceptance. Returns the cycles taken.
    task automatic offer(input logic [31:0] blk, input logic [CNT_W-1:0] n, output int tries);
        load_valid = 1'b1;
        data_in    = blk;
        num_words  = n;
        tries      = 0;
        loaded     = 1'b0;
        while (!loaded && tries < 6) begin
            tick();
            tries++;
        end
        if (!loaded) check("load_accept", 32'd0, 32'd1);
        load_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
        tick();  // one cycle after the block, out_valid must be 0
    endtask

    initial begin
        int tries;
        total      = 0;
        passed     = 0;
        rebuilt    = '0;
        loaded     = 1'b0;
        rst_n      = 1'b1;
        clear      = 1'b0;
        load_valid = 1'b0;
        out_ready  = 1'b1;
        data_in    = '0;
        num_words  = '0;

        // 1. Asynchronous reset in the middle of a cycle.
        #3 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // 2. Full block, num_words = 0, with loopback reconstruction.
        rebuilt = '0;
        offer(32'hA1B2C3D4, 3'd0, tries);
        drain(8);
        check("loopback_full", rebuilt, 32'hA1B2C3D4);

        // 3a. Truncate to two words.
        rebuilt = '0;
        offer(32'hA1B2C3D4, 3'd2, tries);
        drain(8);
        check("trunc2", rebuilt, 32'h0000A1B2);

        // 3b. An out-of-range count gives a full block.
        rebuilt = '0;
        offer(32'hA1B2C3D4, 3'd7, tries);
        drain(8);
        check("count7", rebuilt, 32'hA1B2C3D4);

        // 3c. Backpressure: out_ready 1,0,0,1 keeps B2 on data_out.
        rebuilt = '0;
        offer(32'hA1B2C3D4, 3'd4, tries);
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        out_ready = 1'b1;
        drain(8);
        check("backpressure", rebuilt, 32'hA1B2C3D4);

        // 4. The second block is offered while the last word (44) is showing.
        offer(32'h11223344, 3'd0, tries);
        while (sb.size() > 1 && tries < 10) begin
            tick();
            tries++;
        end
        check("at_last_word", 32'(sb.size()), 32'd1);
        rebuilt = '0;
        offer(32'h55667788, 3'd0, tries);
        check("b2b_gap", 32'(tries - 1), B2B ? 32'd0 : 32'd1);
        drain(8);
        check("b2b_second", rebuilt, 32'h55667788);

        // 5. clear after B2 while a load is offered in the same cycle.
        offer(32'hA1B2C3D4, 3'd0, tries);
        tick();
        tick();
        clear      = 1'b1;
        load_valid = 1'b1;
        data_in    = 32'h0F0E0D0C;
        out_ready  = 1'b0;
        tick();
        clear      = 1'b0;
        load_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        rebuilt = '0;
        offer(32'h0F0E0D0C, 3'd0, tries);
        drain(8);
        check("after_clear", rebuilt, 32'h0F0E0D0C);

        // 6. Reset in the middle of a block, after word A1.
        offer(32'hA1B2C3D4, 3'd0, tries);
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'h00);
        check("midrst_load_ready", 32'(load_ready), 32'd1);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        rebuilt = '0;
        offer(32'h5A6B7C8D, 3'd0, tries);
        drain(8);
        check("after_midrst", rebuilt, 32'h5A6B7C8D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
